serial_adder: RTL and testbench

Parametrised bit-serial adder: accepts two WIDTH-bit operands and a carry-in on a start strobe, then adds them LSB-first over WIDTH clock cycles through one full-adder cell and a carry flip-flop. It reports the result through a single-cycle done pulse and holds sum, carry-out and signed overflow until the next operation. It is the multi-bit, clocked successor to the combinational one-bit adder cell, sized for discrete-logic (7400-series) synthesis, where one adder cell plus shift registers is cheaper than a WIDTH-bit ripple chain.

---
 rtl/serial_adder_pkg.sv | 13 +
 rtl/full_adder.sv | 13 +
 rtl/serial_adder.sv | 143 ++++++++++++++
 tb/tb_serial_adder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encoding and width bounds for serial_adder
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - one-bit full adder cell
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic c_out
);

    assign s     = a ^ b ^ c;
    assign c_out = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - LSB-first bit-serial adder, one full_adder cell plus shift registers
// Optional subtract mode: SERIAL_ADDER_SUB_EN
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
        $error("serial_adder: WIDTH out of range");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             fa_b, fa_s, fa_co;
    logic             load_carry;

`ifdef SERIAL_ADDER_SUB_EN
    logic sub_q, sub_d;
    // Subtraction is a + ~b + 1: invert B on its way into the cell, force carry-in high.
    assign fa_b       = b_q[0] ^ sub_q;
    assign load_carry = sub ? 1'b1 : cin;
`else
    assign fa_b       = b_q[0];
    assign load_carry = cin;
`endif

    full_adder u_fa (
        .a     (a_q[0]),
        .b     (fa_b),
        .c     (carry_q),
        .s     (fa_s),
        .c_out (fa_co)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        work_d  = work_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
`ifdef SERIAL_ADDER_SUB_EN
        sub_d   = sub_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = load_carry;
                    cnt_d   = '0;
                    work_d  = '0;
`ifdef SERIAL_ADDER_SUB_EN
                    sub_d   = sub;
`endif
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                work_d  = {fa_s, work_q[WIDTH-1:1]};
                carry_d = fa_co;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // carry_q here is the carry into the MSB cell.
                    sum_d   = {fa_s, work_q[WIDTH-1:1]};
                    cout_d  = fa_co;
                    ovf_d   = carry_q ^ fa_co;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            work_q  <= work_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    assign busy     = (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder (WIDTH=8)
module tb_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub;
`endif
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
    logic       overflow;

    int n_checks = 0;
    int n_fails  = 0;
    int n;
    int seen_done;

    serial_adder #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub      (sub),
`endif
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [7:0] ta, input logic [7:0] tb, input logic tc);
        a     = ta;
        b     = tb;
        cin   = tc;
        start = 1'b1;
    endtask

    // Counts rising edges (sampled 1ns after) until done; bounded so a dead DUT cannot hang the run.
    task automatic wait_done(input int n0, input bit drop_start, output int cnt);
        cnt = n0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
            if (cnt == 1 && drop_start) start = 1'b0;
        end while (!done && cnt < 40);
    endtask

    task automatic check_result(input string tag, input logic [7:0] es, input logic ec, input logic eo);
        check({tag, "_sum"}, 32'(sum), 32'(es));
        check({tag, "_cout"}, 32'(cout), 32'(ec));
        check({tag, "_ovf"}, 32'(overflow), 32'(eo));
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'($urandom);
        a     = 8'($urandom);
        b     = 8'($urandom);
        cin   = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
        sub   = 1'($urandom);
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check_result("rst", 8'h00, 1'b0, 1'b0);

        start = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub   = 1'b0;
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Plain add, latency and single-cycle done pulse
        start_op(8'h3C, 8'h0F, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("add_busy", 32'(busy), 32'd1);
        wait_done(1, 1'b0, n);
        check("add_latency", 32'(n), 32'd9);
        check("add_busy_in_done", 32'(busy), 32'd0);
        check_result("add", 8'h4B, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("add_done_pulse", 32'(done), 32'd0);
        check("add_sum_hold", 32'(sum), 32'h4B);

        // Carry-in with carry out, then signed overflow without carry out
        start_op(8'hFF, 8'h01, 1'b1);
        wait_done(0, 1'b1, n);
        check("carry_latency", 32'(n), 32'd9);
        check_result("carry", 8'h01, 1'b1, 1'b0);

        start_op(8'h7F, 8'h01, 1'b0);
        wait_done(0, 1'b1, n);
        check("ovf_latency", 32'(n), 32'd9);
        check_result("ovf", 8'h80, 1'b0, 1'b1);

        // Start pulsed mid-RUN with new operands must be ignored
        start_op(8'h11, 8'h22, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("ign_sum_stable", 32'(sum), 32'h80);
        start_op(8'hFF, 8'hFF, 1'b1);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(4, 1'b0, n);
        check("ign_latency", 32'(n), 32'd9);
        check_result("ign", 8'h33, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("ign_not_queued", 32'(busy), 32'd0);

        // Start held high: DONE accepts the next operation directly
        start_op(8'h01, 8'h02, 1'b0);
        @(posedge clk);
        #1;
        a = 8'h05;
        b = 8'h0A;
        wait_done(1, 1'b0, n);
        check("hold1_latency", 32'(n), 32'd9);
        check_result("hold1", 8'h03, 1'b0, 1'b0);
        wait_done(0, 1'b1, n);
        check("hold2_spacing", 32'(n), 32'd9);
        check_result("hold2", 8'h0F, 1'b0, 1'b0);

        // Asynchronous reset during the 4th RUN cycle
        @(posedge clk);
        #1;
        start_op(8'hAA, 8'h55, 1'b1);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("mid_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_done", 32'(done), 32'd0);
        check_result("mid", 8'h00, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done) seen_done++;
        end
        check("mid_no_done", 32'(seen_done), 32'd0);
        start_op(8'h10, 8'h20, 1'b0);
        wait_done(0, 1'b1, n);
        check("post_rst_latency", 32'(n), 32'd9);
        check_result("post_rst", 8'h30, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        // Subtract: cin ignored, cout=1 means no borrow
        sub = 1'b1;
        start_op(8'h10, 8'h01, 1'b0);
        wait_done(0, 1'b1, n);
        check("sub1_latency", 32'(n), 32'd9);
        check("sub1_sum", 32'(sum), 32'h0F);
        check("sub1_cout", 32'(cout), 32'd1);
        start_op(8'h00, 8'h01, 1'b0);
        wait_done(0, 1'b1, n);
        check("sub2_sum", 32'(sum), 32'hFF);
        check("sub2_cout", 32'(cout), 32'd0);
        sub = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
